// File: rtl/pipelined_shifter.sv
// Purpose: barrel shifter/rotator built as a log2(N)-stage pipeline, one power-of-two shift per stage.
// Latency: M cycles from input acceptance to out_valid; one operation per cycle while unstalled.
// Backpressure: a single global advance stalls every stage together; in_ready follows out_ready combinationally.
module pipelined_shifter #(
   parameter int N = 32,   // data width, must equal 2**M
   parameter int M = 5     // shift-amount width and number of pipeline stages
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic [M-1:0] in_amt,
   input  logic [2:0]   in_op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data
);

   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRL = 3'b001;
   localparam logic [2:0] OP_SRA = 3'b010;
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;

   // One fixed-distance step of the selected operation. Every stage calls this
   // with a constant distance, so each instance reduces to plain wiring + muxes.
   // Arithmetic right shift takes its fill from the current MSB, which earlier
   // SRA stages have already replicated, so the sign propagates correctly.
   // Ops 101..111 fall through to the default and pass the data untouched.
   function automatic logic [N-1:0] shift_step(input logic [N-1:0] d,
                                               input logic [2:0]   op,
                                               input int           s);
      logic [N-1:0] r;
      r = d;
      case (op)
         OP_SLL:  r = d << s;
         OP_SRL:  r = d >> s;
         OP_SRA:  r = $unsigned($signed(d) >>> s);
         OP_ROL:  r = (d << s) | (d >> (N - s));
         OP_ROR:  r = (d >> s) | (d << (N - s));
         default: r = d;
      endcase
      return r;
   endfunction

   // The whole pipeline moves as one: it may shift whenever the output slot is
   // empty or being drained. Bubbles in earlier stages are carried along, so an
   // invalid entry never blocks anything behind it.
   logic advance;
   assign advance  = !out_valid || out_ready;

   // Held high during reset so the upstream never sees a stuck handshake; the
   // stage valids are cleared by reset with priority, so nothing gets in.
   assign in_ready = reset || advance;

   for (genvar k = 0; k < M; k++) begin : stg
      logic         v_in;
      logic [N-1:0] d_in;
      logic [2:0]   op_in;
      logic         sh;
      logic [N-1:0] d_nxt;
      logic         vld;
      logic [N-1:0] dat;

      // Stage 0 consumes the input port; later stages consume the previous
      // stage's registers, using the lowest amount bit still carried.
      if (k == 0) begin : g_src
         assign v_in  = in_valid;
         assign d_in  = in_data;
         assign op_in = in_op;
         assign sh    = in_amt[0];
      end else begin : g_src
         assign v_in  = stg[k-1].vld;
         assign d_in  = stg[k-1].dat;
         assign op_in = stg[k-1].g_fwd.op_q;
         assign sh    = stg[k-1].g_fwd.amt_q[k];
      end

      assign d_nxt = sh ? shift_step(d_in, op_in, 2**k) : d_in;

      // Valid bit: cleared by reset (drops all in-flight work), moves on advance.
      always_ff @(posedge clock) begin
         if (reset) begin
            vld <= 1'b0;
         end else if (advance) begin
            vld <= v_in;
         end
      end

      if (k == M - 1) begin : g_last
         // Output register: reset to zero so out_data is defined after reset.
         always_ff @(posedge clock) begin
            if (reset) begin
               dat <= '0;
            end else if (advance) begin
               dat <= d_nxt;
            end
         end
      end else begin : g_mid
         // Partial result; contents only matter when the valid bit is set.
         always_ff @(posedge clock) begin
            if (advance) begin
               dat <= d_nxt;
            end
         end
      end

      // Op and the not-yet-applied amount bits travel with the data. The last
      // stage has no consumer for them, so they stop one stage earlier.
      if (k < M - 1) begin : g_fwd
         logic [2:0]     op_q;
         logic [M-1:k+1] amt_q;

         if (k == 0) begin : g_amt
            // Capture op and the upper amount bits from the input port.
            always_ff @(posedge clock) begin
               if (advance) begin
                  op_q  <= op_in;
                  amt_q <= in_amt[M-1:k+1];
               end
            end
         end else begin : g_amt
            // Pass op along and drop the amount bit this stage just consumed.
            always_ff @(posedge clock) begin
               if (advance) begin
                  op_q  <= op_in;
                  amt_q <= stg[k-1].g_fwd.amt_q[M-1:k+1];
               end
            end
         end
      end
   end

   // Outputs come straight from the last stage registers.
   assign out_valid = stg[M-1].vld;
   assign out_data  = stg[M-1].dat;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: directed vectors feed a scoreboard queue; an
// independent monitor pops and compares on every output transfer, and also
// watches stall behaviour (held outputs, in_ready low).
module tb_pipelined_shifter;

   localparam int N = 32;
   localparam int M = 5;

   logic         clock = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic [M-1:0] in_amt;
   logic [2:0]   in_op;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;

   pipelined_shifter #(.N(N), .M(M)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [N-1:0] data;
      int           acc;
      bit           lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Bit-by-bit reference: each result bit picks its source bit directly.
   function automatic logic [N-1:0] model(input logic [N-1:0] d, input int a, input logic [2:0] op);
      logic [N-1:0] r;
      r = d;
      for (int i = 0; i < N; i++) begin
         case (op)
            3'd0: r[i] = (i >= a) ? d[i-a] : 1'b0;
            3'd1: r[i] = (i + a < N) ? d[i+a] : 1'b0;
            3'd2: r[i] = (i + a < N) ? d[i+a] : d[N-1];
            3'd3: r[i] = d[(i - a + N) % N];
            3'd4: r[i] = d[(i + a) % N];
            default: r[i] = d[i];
         endcase
      end
      return r;
   endfunction

   // Called at a falling edge; presents one op, waits (bounded) for in_ready,
   // records the expectation and returns at the falling edge after the transfer.
   task automatic send(input logic [N-1:0] d, input logic [M-1:0] a, input logic [2:0] op,
                       input logic [N-1:0] exp, input bit lat);
      int   waited;
      exp_t e;
      waited   = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_amt   = a;
      in_op    = op;
      #1;
      while (!in_ready && waited < 100) begin
         @(negedge clock);
         #1;
         waited++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready stuck at 0, required 1 within 100 cycles");
      end else begin
         e.data = exp;
         e.acc  = cyc;
         e.lat  = lat;
         sb.push_back(e);
      end
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 200) begin
         @(negedge clock);
         w++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      end
   endtask

   // Monitor: samples after the driver settles on each falling edge.
   initial begin
      bit           prev_stall;
      logic [N-1:0] prev_data;
      exp_t         e;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clock);
         #2;
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("hold_valid", {31'b0, out_valid}, 32'd1);
               chk("hold_data", out_data, prev_data);
            end
            if (out_valid && !out_ready) begin
               chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL spurious_output: got out_valid=1 data 0x%08h, expected no output", out_data);
               end else begin
                  e = sb.pop_front();
                  chk("result_data", out_data, e.data);
                  if (e.lat) chk("latency", cyc - e.acc, M);
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
         end
      end
   end

   // Directed vectors with hand-computed results.
   logic [N-1:0] vd  [13] = '{32'h0000_0001, 32'h8000_00F0, 32'h8000_00F0, 32'h1234_5678,
                              32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h7000_0000,
                              32'h8000_0001, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h8000_0000,
                              32'h0000_0001};
   logic [M-1:0] va  [13] = '{5'd31, 5'd4, 5'd4, 5'd8, 5'd8, 5'd0, 5'd5, 5'd4,
                              5'd1, 5'd31, 5'd0, 5'd31, 5'd1};
   logic [2:0]   vo  [13] = '{3'd0, 3'd2, 3'd1, 3'd4, 3'd3, 3'd0, 3'd7, 3'd2,
                              3'd3, 3'd1, 3'd4, 3'd2, 3'd4};
   logic [N-1:0] ve  [13] = '{32'h8000_0000, 32'hF800_000F, 32'h0800_000F, 32'h7812_3456,
                              32'h3456_7812, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0700_0000,
                              32'h0000_0003, 32'h0000_0001, 32'hDEAD_BEEF, 32'hFFFF_FFFF,
                              32'h8000_0000};

   initial begin
      logic [N-1:0] d;
      logic [M-1:0] a;
      logic [2:0]   op;

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_amt    = '0;
      in_op     = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset_out_data", out_data, 32'd0);
      chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
      reset = 1'b0;
      @(negedge clock);

      // Back-to-back directed ops, no stall: exact M-cycle latency each.
      for (int i = 0; i < 13; i++) send(vd[i], va[i], vo[i], ve[i], 1'b1);
      drain();

      // Burst of 8 with a 4-cycle consumer stall overlapping the first outputs.
      fork
         begin
            repeat (5) @(negedge clock);
            out_ready = 1'b0;
            repeat (4) @(negedge clock);
            out_ready = 1'b1;
         end
      join_none
      for (int i = 0; i < 8; i++) begin
         d  = $urandom;
         a  = 5'($urandom_range(0, 31));
         op = 3'(i % 6);
         send(d, a, op, model(d, int'(a), op), 1'b0);
      end
      drain();
      repeat (4) @(negedge clock);

      // Reset with three entries in flight: none of them may surface.
      send(32'h0000_00AA, 5'd3, 3'd0, 32'h0000_0550, 1'b0);
      send(32'h0000_00BB, 5'd1, 3'd1, 32'h0000_005D, 1'b0);
      send(32'h0000_00CC, 5'd2, 3'd3, 32'h0000_0330, 1'b0);
      reset = 1'b1;
      sb.delete();
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
      chk("flush_out_data", out_data, 32'd0);
      repeat (M + 1) begin
         @(negedge clock);
         #1;
         chk("flush_quiet", {31'b0, out_valid}, 32'd0);
      end
      @(negedge clock);
      send(32'h0000_0001, 5'd31, 3'd0, 32'h8000_0000, 1'b1);
      drain();

      // Reset while the output is stalled: in_ready forced high, the input
      // presented during reset is not taken.
      out_ready = 1'b0;
      send(32'h0000_00FF, 5'd4, 3'd0, 32'h0000_0FF0, 1'b0);
      repeat (M) @(negedge clock);
      #1;
      chk("stalled_out_valid", {31'b0, out_valid}, 32'd1);
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'hAAAA_5555;
      in_amt   = 5'd0;
      in_op    = 3'd0;
      sb.delete();
      #1;
      chk("reset_stall_in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clock);
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("reset2_out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset2_out_data", out_data, 32'd0);
      repeat (M + 1) begin
         @(negedge clock);
         #1;
         chk("reset2_quiet", {31'b0, out_valid}, 32'd0);
      end
      @(negedge clock);
      send(32'h1234_5678, 5'd8, 3'd4, 32'h7812_3456, 1'b1);
      drain();
      repeat (3) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1);
   end

endmodule
